soc_disp_scan: RTL and testbench

Multiplexed 8-digit seven-segment display driver that sits downstream of the SoC general-purpose outputs. It consumes the 32-bit result word (gpO2) and the display-select and factorial-error status bits (gpO1[4], gpO1[0]), then drives board anodes and cathodes. It shows hex or decimal, with leading-zero blanking and an "Err" override. Input sampling is frame-synchronous, so a digit pattern never tears mid-scan.

---
 rtl/disp_pkg.sv | 111 +++++++++++
 rtl/soc_disp_scan_if.sv | 32 +++
 rtl/bin2bcd_seq.sv | 96 +++++++++
 rtl/soc_disp_scan.sv | 149 ++++++++++++++
 tb/tb_soc_disp_scan.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants, types and helper functions for the seven-segment display
// scanner: digit count, active-low glyph encodings ({g,f,e,d,c,b,a}), the
// glyph-code enum, FSM state types and word-to-glyph conversion helpers.
// -----------------------------------------------------------------------------
package disp_pkg;

   localparam int          NUM_DIGITS = 8;
   localparam logic [31:0] DEC_MAX    = 32'd99_999_999;

   typedef logic [6:0]                  glyph_t;
   typedef glyph_t [NUM_DIGITS-1:0]     glyph_buf_t;

   // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}.
   localparam glyph_t GLYPH_0     = 7'h40;
   localparam glyph_t GLYPH_1     = 7'h79;
   localparam glyph_t GLYPH_2     = 7'h24;
   localparam glyph_t GLYPH_3     = 7'h30;
   localparam glyph_t GLYPH_4     = 7'h19;
   localparam glyph_t GLYPH_5     = 7'h12;
   localparam glyph_t GLYPH_6     = 7'h02;
   localparam glyph_t GLYPH_7     = 7'h78;
   localparam glyph_t GLYPH_8     = 7'h00;
   localparam glyph_t GLYPH_9     = 7'h10;
   localparam glyph_t GLYPH_A     = 7'h08;
   localparam glyph_t GLYPH_B     = 7'h03;
   localparam glyph_t GLYPH_C     = 7'h46;
   localparam glyph_t GLYPH_D     = 7'h21;
   localparam glyph_t GLYPH_E     = 7'h06;
   localparam glyph_t GLYPH_F     = 7'h0E;
   localparam glyph_t GLYPH_R     = 7'h2F;
   localparam glyph_t GLYPH_DASH  = 7'h3F;
   localparam glyph_t GLYPH_BLANK = 7'h7F;

   localparam glyph_buf_t BLANK_GLYPHS = {NUM_DIGITS{GLYPH_BLANK}};
   localparam glyph_buf_t DASH_GLYPHS  = {NUM_DIGITS{GLYPH_DASH}};
   localparam glyph_buf_t ERR_GLYPHS   = {{(NUM_DIGITS-3){GLYPH_BLANK}},
                                          GLYPH_E, GLYPH_R, GLYPH_R};

   // Codes 0..15 coincide with the nibble value, so a nibble casts directly.
   typedef enum logic [4:0] {
      GC_0, GC_1, GC_2, GC_3, GC_4, GC_5, GC_6, GC_7,
      GC_8, GC_9, GC_A, GC_B, GC_C, GC_D, GC_E, GC_F,
      GC_R, GC_DASH, GC_BLANK
   } glyph_code_e;

   typedef enum logic [1:0] {
      BCD_IDLE,
      BCD_SHIFT,
      BCD_DONE
   } bcd_state_e;

   typedef enum logic [1:0] {
      FMT_IDLE,
      FMT_WAIT_BCD,
      FMT_READY
   } fmt_state_e;

   function automatic glyph_t code_glyph(input glyph_code_e code);
      case (code)
         GC_0:    return GLYPH_0;
         GC_1:    return GLYPH_1;
         GC_2:    return GLYPH_2;
         GC_3:    return GLYPH_3;
         GC_4:    return GLYPH_4;
         GC_5:    return GLYPH_5;
         GC_6:    return GLYPH_6;
         GC_7:    return GLYPH_7;
         GC_8:    return GLYPH_8;
         GC_9:    return GLYPH_9;
         GC_A:    return GLYPH_A;
         GC_B:    return GLYPH_B;
         GC_C:    return GLYPH_C;
         GC_D:    return GLYPH_D;
         GC_E:    return GLYPH_E;
         GC_F:    return GLYPH_F;
         GC_R:    return GLYPH_R;
         GC_DASH: return GLYPH_DASH;
         default: return GLYPH_BLANK;
      endcase
   endfunction

   function automatic glyph_t hex_to_glyph(input logic [3:0] nib);
      return code_glyph(glyph_code_e'({1'b0, nib}));
   endfunction

   // Eight hex nibbles, no blanking.
   function automatic glyph_buf_t hex_word_glyphs(input logic [31:0] word);
      glyph_buf_t g;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         g[i] = hex_to_glyph(word[4*i +: 4]);
      end
      return g;
   endfunction

   // Packed BCD to glyphs with leading-zero blanking; digit 0 always shows.
   function automatic glyph_buf_t bcd_word_glyphs(input logic [31:0] bcd);
      glyph_buf_t g;
      logic       lead;
      lead = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (bcd[4*i +: 4] != 4'd0 || i == 0) begin
            lead = 1'b0;
         end
         g[i] = lead ? GLYPH_BLANK : hex_to_glyph(bcd[4*i +: 4]);
      end
      return g;
   endfunction

endpackage

// File: rtl/soc_disp_scan_if.sv
// -----------------------------------------------------------------------------
// soc_disp_scan_if
// Bundle between the SoC general-purpose outputs and the display scanner.
//   value    : 32-bit word to display (gpO2)
//   disp_sel : 0 = hex, 1 = decimal (gpO1[4])
//   fact_err : 1 = show "Err" (gpO1[0])
//   an       : active-low anode enables, an[0] is the rightmost digit
//   seg      : active-low cathodes {g,f,e,d,c,b,a}
//   dp       : active-low decimal point
// master = SoC/board side, slave = display scanner.
// -----------------------------------------------------------------------------
interface soc_disp_scan_if;
   import disp_pkg::*;

   logic [31:0]           value;
   logic                  disp_sel;
   logic                  fact_err;
   logic [NUM_DIGITS-1:0] an;
   glyph_t                seg;
   logic                  dp;

   modport master (
      output value, disp_sel, fact_err,
      input  an, seg, dp
   );

   modport slave (
      input  value, disp_sel, fact_err,
      output an, seg, dp
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential 32-bit binary to 8-digit packed BCD converter (shift-add-3).
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, aborts any conversion
//   start : begin converting bin (accepted only when idle)
//   bin   : binary input, sampled with start
//   busy  : conversion in progress
//   done  : one-cycle pulse, bcd/ovf valid from this cycle until next start
//   bcd   : 8 packed BCD digits, digit 0 in bcd[3:0]
//   ovf   : bin exceeded 99_999_999, bcd digits are not meaningful
// -----------------------------------------------------------------------------
module bin2bcd_seq
   import disp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] bin,
   output logic        busy,
   output logic        done,
   output logic [31:0] bcd,
   output logic        ovf
);

   bcd_state_e  state_q;
   logic [31:0] bin_q;
   logic [31:0] bcd_q;
   logic [31:0] bcd_adj_d;
   logic [4:0]  cnt_q;
   logic        busy_q;
   logic        done_q;
   logic        ovf_q;

   // Add-3 correction applied to every digit before each shift.
   always_comb begin
      // NOTE: assign a default before the loop so no path leaves bcd_adj_d unassigned (no latch).
      bcd_adj_d = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // NOTE: state and datapath registers use non-blocking assignments so each
   // branch reads pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= BCD_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            BCD_IDLE: begin
               if (start) begin
                  // The first three shifts can never produce a digit >= 5,
                  // so they are folded into the load; 29 shift cycles remain.
                  bcd_q   <= {29'd0, bin[31:29]};
                  bin_q   <= {bin[28:0], 3'd0};
                  cnt_q   <= 5'd3;
                  ovf_q   <= (bin > DEC_MAX);
                  busy_q  <= 1'b1;
                  state_q <= BCD_SHIFT;
               end
            end
            BCD_SHIFT: begin
               {bcd_q, bin_q} <= {bcd_adj_d, bin_q} << 1;
               cnt_q          <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= BCD_DONE;
               end
            end
            BCD_DONE: begin
               state_q <= BCD_IDLE;
            end
            default: begin
               state_q <= BCD_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: rtl/soc_disp_scan.sv
// -----------------------------------------------------------------------------
// soc_disp_scan
// Multiplexed 8-digit seven-segment driver. Inputs are sampled only at the
// frame boundary (last cycle of digit 7), formatted into a staged buffer and
// committed to the display buffer at the following boundary, so a frame never
// shows a mix of old and new digits.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of soc_disp_scan_if (value/disp_sel/fact_err in,
//         an/seg/dp out, all outputs active-low and registered)
// Parameter REFRESH_DIV: clock cycles each digit is lit (REFRESH_DIV*8 >= 36).
// -----------------------------------------------------------------------------
module soc_disp_scan
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
) (
   input  logic            clk,
   input  logic            rst,
   soc_disp_scan_if.slave  bus
);

   localparam int                DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int                IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // Scan counter
   logic [DIV_W-1:0]      div_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  div_wrap;
   logic                  frame_end;

   // Shadows, buffers and formatter
   logic [31:0]           value_sh_q;
   logic                  sel_sh_q;
   logic                  err_sh_q;
   glyph_buf_t            staged_q;
   glyph_buf_t            disp_q;
   fmt_state_e            fmt_state_q;

   // Converter
   logic                  bcd_start;
   logic                  bcd_busy;
   logic                  bcd_done;
   logic [31:0]           bcd_val;
   logic                  bcd_ovf;

   // Output registers
   logic [NUM_DIGITS-1:0] an_q;
   glyph_t                seg_q;

   assign div_wrap  = (div_q == DIV_LAST);
   assign frame_end = div_wrap && (idx_q == IDX_LAST);

   // The converter samples the live inputs on the boundary edge, i.e. the
   // same values the shadows capture on that edge.
   assign bcd_start = frame_end && bus.disp_sel && !bus.fact_err && !bcd_busy;

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (bcd_start),
      .bin   (bus.value),
      .busy  (bcd_busy),
      .done  (bcd_done),
      .bcd   (bcd_val),
      .ovf   (bcd_ovf)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q <= '0;
         idx_q <= '0;
      end else begin
         div_q <= div_wrap ? '0 : div_q + 1'b1;
         if (div_wrap) begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   // Shadow capture and display commit happen together on the boundary edge;
   // the commit takes the staged content formatted during the previous frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_sh_q <= '0;
         sel_sh_q   <= 1'b0;
         err_sh_q   <= 1'b0;
         // NOTE: the glyph buffers are plain flops, not RAM, and must come out
         // of reset blank, so they are cleared in the reset branch.
         disp_q     <= BLANK_GLYPHS;
      end else if (frame_end) begin
         value_sh_q <= bus.value;
         sel_sh_q   <= bus.disp_sel;
         err_sh_q   <= bus.fact_err;
         disp_q     <= staged_q;
      end
   end

   // Formatter: a boundary always (re)starts formatting; hex and error
   // patterns are ready one cycle later, decimal waits for the converter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fmt_state_q <= FMT_IDLE;
         staged_q    <= BLANK_GLYPHS;
      end else if (frame_end) begin
         fmt_state_q <= FMT_WAIT_BCD;
      end else begin
         case (fmt_state_q)
            FMT_WAIT_BCD: begin
               if (err_sh_q) begin
                  staged_q    <= ERR_GLYPHS;
                  fmt_state_q <= FMT_READY;
               end else if (!sel_sh_q) begin
                  staged_q    <= hex_word_glyphs(value_sh_q);
                  fmt_state_q <= FMT_READY;
               end else if (bcd_done) begin
                  staged_q    <= bcd_ovf ? DASH_GLYPHS : bcd_word_glyphs(bcd_val);
                  fmt_state_q <= FMT_READY;
               end
            end
            FMT_IDLE,
            FMT_READY: begin
               fmt_state_q <= fmt_state_q;
            end
            default: begin
               fmt_state_q <= FMT_IDLE;
            end
         endcase
      end
   end

   // Outputs follow idx one cycle late; seg reads the buffer after the commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_q  <= '1;
         seg_q <= GLYPH_BLANK;
      end else begin
         an_q  <= ~(NUM_DIGITS'(1) << idx_q);
         seg_q <= disp_q[idx_q];
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_soc_disp_scan.sv
// -----------------------------------------------------------------------------
// tb_soc_disp_scan
// Scoreboard bench for soc_disp_scan with REFRESH_DIV=4 (32-cycle frame).
// The stimulus process drives one frame of inputs at a time and pushes the
// eight {an, seg} pairs it expects for that frame; the monitor pops one entry
// each time a new digit appears on the anodes and also checks digit hold time
// and seg stability within a digit.
// -----------------------------------------------------------------------------
module tb_soc_disp_scan;
   import disp_pkg::*;

   localparam int RD    = 4;
   localparam int FRAME = RD * NUM_DIGITS;

   typedef struct packed {
      logic [7:0] an;
      glyph_t     seg;
   } exp_t;

   // Hand-derived glyph frames, digit 7 first.
   localparam glyph_buf_t BLANKS      = {8{7'h7F}};
   localparam glyph_buf_t CAP_A5      = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12};
   localparam glyph_buf_t CAP_120     = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40};
   localparam glyph_buf_t ALL_DASH    = {8{7'h3F}};
   localparam glyph_buf_t CAP_ERR     = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F};
   localparam glyph_buf_t CAP_5_DEC   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12};
   localparam glyph_buf_t ALL_ZERO    = {8{7'h40}};
   localparam glyph_buf_t ALL_F       = {8{7'h0E}};
   localparam glyph_buf_t ALL_NINE    = {8{7'h10}};
   localparam glyph_buf_t CAP_0_DEC   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam glyph_buf_t CAP_1234H   = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
   localparam glyph_buf_t CAP_9ABCH   = {7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40};
   localparam glyph_buf_t CAP_5_HEX   = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12};

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   soc_disp_scan_if u_if ();

   soc_disp_scan #(.REFRESH_DIV(RD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   exp_t       exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   bit         mon_en  = 1'b0;
   glyph_buf_t hist0;
   glyph_buf_t hist1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // One frame: push what should be shown now (captured two boundaries ago),
   // drive inputs for this frame's closing boundary, optionally change value
   // mid-frame, then return just after the boundary edge.
   task automatic run_frame(input logic [31:0] v, input logic sel, input logic err,
                            input glyph_buf_t cap, input int chg_cyc,
                            input logic [31:0] chg_val);
      exp_t e;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         e.an  = 8'(~(8'd1 << i));
         e.seg = hist1[i];
         exp_q.push_back(e);
      end
      u_if.value    = v;
      u_if.disp_sel = sel;
      u_if.fact_err = err;
      for (int c = 0; c < FRAME; c++) begin
         @(posedge clk);
         if (c == chg_cyc) begin
            #1;
            u_if.value = chg_val;
         end
      end
      @(negedge clk);
      hist1 = hist0;
      hist0 = cap;
   endtask

   // Monitor: a change of anode pattern means a new digit is presented.
   logic [7:0] prev_an;
   glyph_t     cur_seg;
   int         run_len;
   exp_t       got;

   always @(negedge clk) begin
      if (!mon_en) begin
         prev_an = 8'hFF;
         cur_seg = 7'h7F;
         run_len = 0;
      end else if (u_if.an !== prev_an) begin
         if (prev_an != 8'hFF) begin
            check("digit_hold_cycles", 64'(run_len), 64'(RD));
         end
         if (exp_q.size() == 0) begin
            check("unexpected_digit", 64'(u_if.an), 64'hFF);
         end else begin
            got = exp_q.pop_front();
            check("anode", 64'(u_if.an), 64'(got.an));
            check("segments", 64'(u_if.seg), 64'(got.seg));
         end
         prev_an = u_if.an;
         cur_seg = u_if.seg;
         run_len = 1;
      end else begin
         run_len++;
         check("seg_stable_in_digit", 64'(u_if.seg), 64'(cur_seg));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b0;
      u_if.value    = '0;
      u_if.disp_sel = 1'b0;
      u_if.fact_err = 1'b0;
      hist0         = BLANKS;
      hist1         = BLANKS;

      repeat (3) @(negedge clk);
      check("reset_an", 64'(u_if.an), 64'hFF);
      check("reset_seg", 64'(u_if.seg), 64'h7F);
      check("reset_dp", 64'(u_if.dp), 64'h1);

      rst    = 1'b1;
      mon_en = 1'b1;

      run_frame(32'h0000_00A5, 1'b0, 1'b0, CAP_A5,    -1, '0);
      run_frame(32'd120,       1'b1, 1'b0, CAP_120,   -1, '0);
      run_frame(32'd479001600, 1'b1, 1'b0, ALL_DASH,  -1, '0);
      run_frame(32'd5,         1'b1, 1'b1, CAP_ERR,   -1, '0);
      run_frame(32'd5,         1'b1, 1'b0, CAP_5_DEC, -1, '0);
      run_frame(32'h0,         1'b0, 1'b0, ALL_ZERO,  -1, '0);
      run_frame(32'h0,         1'b0, 1'b0, ALL_ZERO,  -1, '0);
      // Value changes at cycle 10; the frame on screen must not change.
      run_frame(32'h0,         1'b0, 1'b0, ALL_F,     10, 32'hFFFF_FFFF);
      run_frame(32'hFFFF_FFFF, 1'b0, 1'b0, ALL_F,     -1, '0);
      run_frame(32'd99_999_999,  1'b1, 1'b0, ALL_NINE,  -1, '0);
      run_frame(32'd100_000_000, 1'b1, 1'b0, ALL_DASH,  -1, '0);
      run_frame(32'd0,         1'b1, 1'b0, CAP_0_DEC, -1, '0);
      run_frame(32'h1234_5678, 1'b0, 1'b0, CAP_1234H, -1, '0);
      run_frame(32'h9ABC_DEF0, 1'b0, 1'b0, CAP_9ABCH, -1, '0);
      run_frame(32'h0,         1'b0, 1'b0, ALL_ZERO,  -1, '0);
      run_frame(32'h0,         1'b0, 1'b0, ALL_ZERO,  -1, '0);
      // Decimal capture whose conversion gets aborted by reset.
      run_frame(32'd1234,      1'b1, 1'b0, BLANKS,    -1, '0);

      mon_en = 1'b0;
      exp_q.delete();
      repeat (9) @(negedge clk);
      check("bcd_busy_before_reset", 64'(dut.u_bcd.busy), 64'h1);

      #2;
      rst = 1'b0;
      #1;
      check("async_reset_an", 64'(u_if.an), 64'hFF);
      check("async_reset_seg", 64'(u_if.seg), 64'h7F);
      check("async_reset_bcd_busy", 64'(dut.u_bcd.busy), 64'h0);
      check("async_reset_staged", 64'(dut.staged_q), 64'(BLANKS));
      check("async_reset_display", 64'(dut.disp_q), 64'(BLANKS));

      u_if.value    = 32'h5;
      u_if.disp_sel = 1'b0;
      u_if.fact_err = 1'b0;
      hist0         = BLANKS;
      hist1         = BLANKS;
      repeat (2) @(negedge clk);
      rst    = 1'b1;
      mon_en = 1'b1;

      run_frame(32'h5, 1'b0, 1'b0, CAP_5_HEX, -1, '0);
      run_frame(32'h5, 1'b0, 1'b0, CAP_5_HEX, -1, '0);
      run_frame(32'h5, 1'b0, 1'b0, CAP_5_HEX, -1, '0);

      check("all_digits_presented", 64'(exp_q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
